// File: rtl/memfifo_pkg.sv
// rtl/memfifo_pkg.sv - shared state type, widths and header helper for the memfifo packet reader
package memfifo_pkg;

  localparam int          WORD_W          = 64;
  localparam int          CNT_W           = 17;
  localparam logic [15:0] HDR_TAG_DEFAULT = 16'hA5A5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_XFER,
    S_DONE
  } state_e;

  // Header word layout: tag in the top 16 bits, packet count in the bottom 16
  function automatic logic [WORD_W-1:0] hdr_word(input logic [15:0] tag, input logic [15:0] pckts);
    return {tag, 32'h0, pckts};
  endfunction

endpackage

// File: rtl/memfifo_out_stage.sv
// rtl/memfifo_out_stage.sv - output register slice holding data, valid, SOP and EOP under backpressure
module memfifo_out_stage
  import memfifo_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ld_i,
  input  logic [WORD_W-1:0] ld_data_i,
  input  logic              ld_sop_i,
  input  logic              ld_eop_i,
  input  logic              abort_i,
  input  logic              ready_i,
  output logic [WORD_W-1:0] data_o,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o
);

  // Load a new word, drop valid on abort or acceptance, otherwise hold everything
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
    end else if (abort_i) begin
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
    end else if (ld_i) begin
      data_o  <= ld_data_i;
      valid_o <= 1'b1;
      sop_o   <= ld_sop_i;
      eop_o   <= ld_eop_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
    end
  end

endmodule

// File: rtl/memfifo_pckt_reader.sv
// rtl/memfifo_pckt_reader.sv - block reader from memfifo to packet stream; optional timeout via MEMFIFO_TIMEOUT_EN
module memfifo_pckt_reader
  import memfifo_pkg::*;
#(
  parameter logic [15:0] HDR_TAG        = HDR_TAG_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MEMFIFO_DATA_READY,
  input  logic [15:0]       MEMFIFO_DATA_PCKTS,
  input  logic [WORD_W-1:0] MEMFIFO_DATA,
  input  logic              MEMFIFO_EMPTY,
  output logic              MEMFIFO_RE,
  output logic [WORD_W-1:0] PCKT_DATA,
  output logic              PCKT_VALID,
  input  logic              PCKT_READY,
  output logic              PCKT_SOP,
  output logic              PCKT_EOP,
  output logic              BUSY,
  output logic              BLOCK_DONE,
  output logic              TIMEOUT_ERR
);

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              start;
  logic              pop;
  logic              timeout_hit;
  logic              ld;
  logic [WORD_W-1:0] ld_data;
  logic              ld_sop;
  logic              ld_eop;

  // Reset asserts immediately and releases two clocks after RESET_N rises
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign accept = PCKT_VALID && PCKT_READY;
  assign start  = (state_q == S_IDLE) && MEMFIFO_DATA_READY;
  // Popping is allowed while the header is being accepted so data follows it back-to-back
  assign pop    = ((state_q == S_HEADER) || (state_q == S_XFER)) && !MEMFIFO_EMPTY &&
                  (!PCKT_VALID || PCKT_READY) && (cnt_q != '0);

  assign MEMFIFO_RE = pop;
  assign BUSY       = (state_q != S_IDLE);
  assign BLOCK_DONE = accept && PCKT_EOP;

  // Output slice loads the header on block start, otherwise the FIFO head on each pop
  always_comb begin
    ld     = start || pop;
    ld_sop = start;
    if (start) begin
      ld_data = hdr_word(HDR_TAG, MEMFIFO_DATA_PCKTS);
      ld_eop  = (MEMFIFO_DATA_PCKTS == 16'd0);
    end else begin
      ld_data = MEMFIFO_DATA;
      ld_eop  = (cnt_q == CNT_W'(1));
    end
  end

  // Block sequencing and remaining-word counter
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      if (pop) cnt_q <= cnt_q - CNT_W'(1);
      case (state_q)
        S_IDLE: begin
          if (MEMFIFO_DATA_READY) begin
            state_q <= S_HEADER;
            cnt_q   <= {MEMFIFO_DATA_PCKTS, 1'b0};
          end
        end
        S_HEADER: if (accept) state_q <= PCKT_EOP ? S_DONE : S_XFER;
        S_XFER:   if (timeout_hit || (accept && PCKT_EOP)) state_q <= S_DONE;
        S_DONE:   if (!MEMFIFO_DATA_READY) state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MEMFIFO_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  assign timeout_hit = (state_q == S_XFER) && MEMFIFO_EMPTY && (cnt_q != '0) &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive empty cycles in XFER; sticky error cleared when a new block starts
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q != S_XFER) || pop) tmo_q <= '0;
      else if (MEMFIFO_EMPTY && (cnt_q != '0)) tmo_q <= tmo_q + TMO_W'(1);
      if (start)            err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end
  assign TIMEOUT_ERR = err_q;
`else
  assign timeout_hit = 1'b0;
  // Constant 0: without the timeout feature XFER waits indefinitely
  assign TIMEOUT_ERR = (TIMEOUT_CYCLES < 0);
`endif

  memfifo_out_stage u_out_stage (
    .clk_i     (CLK),
    .rst_ni    (rst_n),
    .ld_i      (ld),
    .ld_data_i (ld_data),
    .ld_sop_i  (ld_sop),
    .ld_eop_i  (ld_eop),
    .abort_i   (timeout_hit),
    .ready_i   (PCKT_READY),
    .data_o    (PCKT_DATA),
    .valid_o   (PCKT_VALID),
    .sop_o     (PCKT_SOP),
    .eop_o     (PCKT_EOP)
  );

endmodule
